// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg: datapath width, default reset PC and fetch FSM state encodings.
package pc_fetch_pkg;
  localparam int CPU_WIDTH = 32;
  localparam logic [CPU_WIDTH-1:0] DEFAULT_RESET_PC = '0;
  typedef enum logic [1:0] {
    FETCH_REQ   = 2'b00,
    FETCH_WAIT  = 2'b01,
    FETCH_VALID = 2'b10,
    FETCH_FAULT = 2'b11
  } fetch_state_e;
endpackage

// File: rtl/pc_fetch.sv
// pc_fetch: PC register, imem req/gnt/rvalid handshake and single-entry decode holding register.
// Define PC_FETCH_ALIGN_CHK_EN to trap misaligned next_pc into a sticky FAULT state.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [CPU_WIDTH-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 halt,
  output logic [CPU_WIDTH-1:0] curr_pc,
  output logic                 pc_ena,
  input  logic [CPU_WIDTH-1:0] next_pc,
  output logic                 imem_req,
  output logic [CPU_WIDTH-1:0] imem_addr,
  input  logic                 imem_gnt,
  input  logic                 imem_rvalid,
  input  logic [CPU_WIDTH-1:0] imem_rdata,
  output logic                 inst_valid,
  output logic [CPU_WIDTH-1:0] inst,
  output logic [CPU_WIDTH-1:0] inst_pc,
  input  logic                 inst_ready,
  output logic [31:0]          inst_cnt,
  output logic                 fetch_fault
);
  fetch_state_e state;
  logic [CPU_WIDTH-1:0] pc;
  fetch_state_e accept_state;
  always_comb begin
    imem_req   = (state == FETCH_REQ) & ~halt & ~rst;
    inst_valid = state == FETCH_VALID;
    pc_ena     = inst_valid & inst_ready;
    curr_pc    = pc;
    inst_pc    = pc;
`ifdef PC_FETCH_ALIGN_CHK_EN
    imem_addr    = pc;
    fetch_fault  = state == FETCH_FAULT;
    accept_state = (next_pc[1:0] != 2'b00) ? FETCH_FAULT : FETCH_REQ;
`else
    imem_addr    = {pc[CPU_WIDTH-1:2], 2'b00};
    fetch_fault  = 1'b0;
    accept_state = FETCH_REQ;
`endif
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= FETCH_REQ;
      pc       <= RESET_PC;
      inst     <= '0;
      inst_cnt <= '0;
    end else begin
      case (state)
        FETCH_REQ: if (imem_req & imem_gnt) state <= FETCH_WAIT;
        FETCH_WAIT:
          if (imem_rvalid) begin
            inst  <= imem_rdata;
            state <= FETCH_VALID;
          end
        FETCH_VALID:
          if (inst_ready) begin
            pc       <= next_pc;
            inst_cnt <= inst_cnt + 32'd1;
            state    <= accept_state;
          end
        default: state <= state;
      endcase
    end
endmodule
